// File: rtl/sandpile_pkg.sv
// Shared constants, FSM state encoding and LFSR helpers for the sandpile drop sequencer.
package sandpile_pkg;

    localparam int GRID_W  = 9;
    localparam int SPEED_W = 12;
    localparam int SEED_W  = 10;

    // Fibonacci taps for x^10 + x^7 + 1, expressed as bit indices of the shift register
    localparam int LFSR_TAP_HI = 9;
    localparam int LFSR_TAP_LO = 6;

    localparam logic [9:0] LFSR_ZERO_SEED = 10'h001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_PICK  = 3'd2,
        ST_DROP  = 3'd3,
        ST_SWEEP = 3'd4
    } state_t;

    function automatic logic [9:0] lfsr_next(input logic [9:0] v);
        return {v[8:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/sandpile_lfsr.sv
// Position LFSR: reloads from the seed (zero seed mapped to a non-zero state), steps on request.
module sandpile_lfsr #(
    parameter int SEED_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [SEED_W-1:0] seed,
    input  logic              step,
    output logic [SEED_W-1:0] value
);
    import sandpile_pkg::*;

    logic [SEED_W-1:0] r_lfsr;
    logic [SEED_W-1:0] w_seed_eff;

    assign w_seed_eff = (seed == {SEED_W{1'b0}}) ? SEED_W'(LFSR_ZERO_SEED) : seed;
    assign value      = r_lfsr;

    // Shift register: load has priority over stepping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED_W'(LFSR_ZERO_SEED);
        end else if (load) begin
            r_lfsr <= w_seed_eff;
        end else if (step) begin
            r_lfsr <= SEED_W'(lfsr_next(10'(r_lfsr)));
        end else begin
            r_lfsr <= r_lfsr;
        end
    end

endmodule

// File: rtl/sandpile_sequencer.sv
// Drop sequencer: paces drops, picks centre or random coordinates, and repeats topple sweeps until stable.
module sandpile_sequencer #(
    parameter int GRID_W  = 9,
    parameter int SPEED_W = 12,
    parameter int SEED_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              reset_software_i,
    input  logic [GRID_W-1:0] grid_size_i,
    input  logic              drop_mode_i,
    input  logic [SPEED_W-1:0] speed_i,
    input  logic [SEED_W-1:0] random_seed_i,
    input  logic              drop_ready_i,
    input  logic              topple_done_i,
    input  logic              topple_changed_i,
    output logic              drop_valid_o,
    output logic [GRID_W-1:0] drop_x_o,
    output logic [GRID_W-1:0] drop_y_o,
    output logic              sweep_start_o,
    output logic              busy_o
);
    import sandpile_pkg::*;

    state_t             r_state;
    logic [SPEED_W-1:0] r_cnt;
    logic               r_have_x;
    logic               r_drop_valid;
    logic               r_sweep_start;
    logic               r_busy;
    logic [GRID_W-1:0]  r_x;
    logic [GRID_W-1:0]  r_y;

    logic [SEED_W-1:0]  w_lfsr;
    logic               w_lfsr_load;
    logic               w_lfsr_step;
    logic [GRID_W-1:0]  w_n_eff;
    logic [GRID_W-1:0]  w_center;
    logic [GRID_W-1:0]  w_cand;
    logic               w_cand_ok;
    logic [SPEED_W-1:0] w_lim_m1;
    logic               w_unused_lfsr_hi;

    assign w_n_eff  = (grid_size_i == {GRID_W{1'b0}}) ? {{(GRID_W-1){1'b0}}, 1'b1} : grid_size_i;
    assign w_center = w_n_eff >> 1;
    assign w_cand   = w_lfsr[GRID_W-1:0];
    assign w_cand_ok = (w_cand < w_n_eff);
    assign w_lim_m1 = (speed_i == {SPEED_W{1'b0}}) ? {SPEED_W{1'b0}}
                                                    : speed_i - {{(SPEED_W-1){1'b0}}, 1'b1};
    assign w_unused_lfsr_hi = ^w_lfsr[SEED_W-1:GRID_W];

    // Seed reload on soft reset and on every start; free-run only while searching for a position
    assign w_lfsr_load = reset_software_i | ((r_state == ST_IDLE) & start_i);
    assign w_lfsr_step = (r_state == ST_PICK) & ~reset_software_i;

    sandpile_lfsr #(.SEED_W(SEED_W)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_lfsr_load),
        .seed  (random_seed_i),
        .step  (w_lfsr_step),
        .value (w_lfsr)
    );

    assign drop_valid_o  = r_drop_valid;
    assign drop_x_o      = r_x;
    assign drop_y_o      = r_y;
    assign sweep_start_o = r_sweep_start;
    assign busy_o        = r_busy;

    // Sequencer FSM with interval counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= {SPEED_W{1'b0}};
            r_have_x      <= 1'b0;
            r_drop_valid  <= 1'b0;
            r_sweep_start <= 1'b0;
            r_busy        <= 1'b0;
            r_x           <= {GRID_W{1'b0}};
            r_y           <= {GRID_W{1'b0}};
        end else if (reset_software_i) begin
            r_state       <= ST_IDLE;
            r_cnt         <= {SPEED_W{1'b0}};
            r_have_x      <= 1'b0;
            r_drop_valid  <= 1'b0;
            r_sweep_start <= 1'b0;
            r_busy        <= 1'b0;
            r_x           <= {GRID_W{1'b0}};
            r_y           <= {GRID_W{1'b0}};
        end else begin
            r_sweep_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= {SPEED_W{1'b0}};
                        r_busy  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!start_i) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= {SPEED_W{1'b0}};
                        r_busy  <= 1'b0;
                    end else if (r_cnt >= w_lim_m1) begin
                        r_cnt <= {SPEED_W{1'b0}};
                        if (drop_mode_i) begin
                            r_state  <= ST_PICK;
                            r_have_x <= 1'b0;
                        end else begin
                            r_state      <= ST_DROP;
                            r_x          <= w_center;
                            r_y          <= w_center;
                            r_drop_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + {{(SPEED_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_PICK: begin
                    if (w_cand_ok) begin
                        if (!r_have_x) begin
                            r_x      <= w_cand;
                            r_have_x <= 1'b1;
                        end else begin
                            r_y          <= w_cand;
                            r_have_x     <= 1'b0;
                            r_state      <= ST_DROP;
                            r_drop_valid <= 1'b1;
                        end
                    end
                end
                // The request is held through start_i falling until the grid takes it
                ST_DROP: begin
                    if (drop_ready_i) begin
                        r_drop_valid  <= 1'b0;
                        r_state       <= ST_SWEEP;
                        r_sweep_start <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (topple_done_i) begin
                        if (topple_changed_i) begin
                            r_sweep_start <= 1'b1;
                        end else begin
                            r_state <= start_i ? ST_WAIT : ST_IDLE;
                            r_busy  <= start_i;
                            r_cnt   <= {SPEED_W{1'b0}};
                        end
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_cnt        <= {SPEED_W{1'b0}};
                    r_drop_valid <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
